// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract engine.
//   state_e : FSM state encodings (2'd3 is unused and recovers to S_IDLE)
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder
//   One-bit full adder built from two half adders and an OR for the carry.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
// HalfAdder
//   One-bit half adder.
//   Ports:
//     a, b  : input bits
//     s     : sum (a ^ b)
//     c     : carry (a & b)
module HalfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  HalfAdder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  HalfAdder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  // Both half-adder carries can never be high together, so OR is exact.
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract engine: one full adder sequenced over two
//   WIDTH-bit operands, LSB first, one bit per clock.
//
//   state  | meaning
//   -------+----------------------------------------------------
//   S_IDLE | waiting for start; operands captured on start
//   S_RUN  | one bit-step per clock, WIDTH steps in total
//   S_DONE | one-cycle done pulse, result/cout/ovf valid
//
//   Ports:
//     clk     : system clock, rising edge
//     reset   : synchronous reset, active-high
//     start   : launch request, sampled only in S_IDLE
//     sub     : 0 = a+b, 1 = a-b, sampled with start
//     a, b    : operands, sampled with start
//     busy    : high while in S_RUN
//     done    : one-cycle pulse in S_DONE
//     result  : registered sum/difference
//     cout    : carry out of MSB (for sub, 1 = no borrow)
//     ovf     : signed two's-complement overflow
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_step;

  full_adder u_fa (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign accept    = (state_q == S_IDLE) && start;
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST_BIT);

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (cnt_q == LAST_BIT) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand shifters, bit counter, running carry, result shifter
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shr_d   = shr_q;
    if (accept) begin
      // Subtraction is a + ~b + 1: invert b once here and seed carry with 1.
      sha_d   = a;
      shb_d   = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      sha_d   = {1'b0, sha_q[WIDTH-1:1]};
      shb_d   = {1'b0, shb_q[WIDTH-1:1]};
      shr_d   = {fa_s, shr_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sha_q   <= '0;
      shb_q   <= '0;
      shr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shr_q   <= shr_d;
    end
  end

  // Output registers update only on the step that enters S_DONE.
  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (last_step) begin
      result_d = {fa_s, shr_q[WIDTH-1:1]};
      cout_d   = fa_c;
      // carry_q here is the carry into the MSB.
      ovf_d    = carry_q ^ fa_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
